imm_alu_sequencer: RTL and testbench
====================================

# imm_alu_sequencer

Hardwired control sequencer for register-immediate ALU instructions (addi, andi, ori) plus halt. Drives the datapath control strobes through instruction fetch, decode and a three-step execute. Sits between the memory/IR side of the datapath and the register file/ALU control inputs, and replaces per-instruction hand-sequenced control. Adds a memory-ready wait state, run/halt control, illegal-opcode trapping and a retired-instruction counter.

## Interface
- BITS, 32, instruction register width
- OPC_MSB, 31, MSB of the 5-bit opcode field; opcode = ir[OPC_MSB:OPC_MSB-4]
- OP_ADDI, 5'b01100, addi opcode
- OP_ANDI, 5'b01101, andi opcode
- OP_ORI, 5'b01110, ori opcode
- OP_HALT, 5'b11011, halt opcode
- CNT_WIDTH, 16, retired-instruction counter width

- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-low (0 = reset on next rising edge)
- run  in  1  1 = fetch/execute enabled; sampled in IDLE and at end of EXEC5
- mem_ready  in  1  memory read data valid; sampled in FETCH1
- ir  in  BITS  current instruction register value (IR output)
- PCout, MARin, IncPC, RZin, Read, MDRin, RZout, PCin, MDRout, IRin  out  1 each  fetch strobes
- Gra, Grb, Rout, RYin, Cout, Rin  out  1 each  register select and operand strobes
- ADD, AND, OR  out  1 each  ALU op select, one-hot, asserted only in EXEC4
- halted  out  1  1 while in HALT
- illegal  out  1  1 while in TRAP
- instr_count  out  CNT_WIDTH  number of retired instructions

## Operation
- Moore FSM. States: IDLE, FETCH0, FETCH1, FETCH2, DECODE, EXEC3, EXEC4, EXEC5, HALT, TRAP.
- Strobes per state, all others 0:
  - FETCH0: PCout, MARin, IncPC, RZin
  - FETCH1: Read, MDRin, RZout, PCin (PCin only in the cycle mem_ready=1)
  - FETCH2: MDRout, IRin
  - DECODE: none
  - EXEC3: Grb, Rout, RYin
  - EXEC4: Cout, RZin, plus ADD/AND/OR per opcode
  - EXEC5: RZout, Gra, Rin
- Transitions:
  - IDLE -> FETCH0 if run=1, else stay.
  - FETCH0 -> FETCH1.
  - FETCH1 -> FETCH2 if mem_ready=1, else stay. Read and MDRin stay high while waiting. PC is loaded once only.
  - FETCH2 -> DECODE.
  - DECODE: addi/andi/ori -> EXEC3; OP_HALT -> HALT; any other opcode -> TRAP.
  - EXEC3 -> EXEC4 -> EXEC5.
  - EXEC5 -> FETCH0 if run=1, else IDLE.
  - HALT and TRAP: hold until reset.
- Opcode is taken from ir in DECODE, then latched into an internal 5-bit register. EXEC4 uses the latched value, so later ir changes have no effect.
- instr_count increments by 1 on the EXEC5 -> next-state edge. It also increments on the DECODE -> HALT edge. It wraps modulo 2^CNT_WIDTH. TRAP does not increment.

## Timing
- Reset: state=IDLE, latched opcode=0, instr_count=0. Every strobe, halted and illegal read 0 on the cycle after the reset edge.
- reset=0 takes priority over all transitions in any state, including mid-FETCH1 wait and EXEC4. No strobe is asserted in the cycle following the reset edge.
- Outputs are decoded from the state register only, valid one clock after the state changes. No combinational path from run, mem_ready or ir to any output.
- Latency with mem_ready held at 1: 7 cycles per instruction (FETCH0 to EXEC5). Each cycle mem_ready is low in FETCH1 adds 1 cycle.
- Back-to-back instructions: FETCH0 of the next instruction immediately follows EXEC5 when run=1.
- run deasserted mid-instruction: the current instruction completes, then the FSM enters IDLE after EXEC5.
- Counter wraps from 2^CNT_WIDTH-1 to 0 without any flag.

## Test plan
- Reset: hold reset=0 for 2 cycles with run=1 and mem_ready=1 -> IDLE, all strobes 0, instr_count=0. Release reset -> FETCH0 strobes appear 1 cycle after IDLE.
- andi: ir opcode 01101, mem_ready=1 -> 7-cycle sequence with AND=1 in EXEC4 only; ADD and OR stay 0; instr_count=1 after EXEC5.
- addi with wait: opcode 01100, mem_ready=0 for 2 FETCH1 cycles -> FETCH1 lasts 3 cycles, PCin pulses exactly once, instruction takes 9 cycles, ADD=1 in EXEC4.
- Illegal and halt: opcode 00000 -> TRAP, illegal=1 held, instr_count unchanged. After reset, opcode 11011 -> HALT, halted=1, instr_count=1.
- Reset mid-operation: reset=0 during EXEC4 of ori -> next cycle IDLE, OR=0, instr_count=0.
- Counter wrap: CNT_WIDTH=2, run 5 ori instructions back-to-back -> instr_count sequence 1, 2, 3, 0, 1; run dropped during the 5th -> IDLE after its EXEC5.

Source files
------------

// File: rtl/imm_alu_sequencer.sv
// Hardwired control sequencer for register-immediate ALU instructions (addi/andi/ori) and halt.
// Strobes are registered decodes of the state register, so they trail the state by one clock.
module imm_alu_sequencer #(
   parameter int unsigned BITS      = 32,
   parameter int unsigned OPC_MSB   = 31,
   parameter int unsigned CNT_WIDTH = 16,
   parameter logic [4:0]  OP_ADDI   = 5'b01100,
   parameter logic [4:0]  OP_ANDI   = 5'b01101,
   parameter logic [4:0]  OP_ORI    = 5'b01110,
   parameter logic [4:0]  OP_HALT   = 5'b11011
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 mem_ready,
   input  logic [BITS-1:0]      ir,
   output logic                 PCout,
   output logic                 MARin,
   output logic                 IncPC,
   output logic                 RZin,
   output logic                 Read,
   output logic                 MDRin,
   output logic                 RZout,
   output logic                 PCin,
   output logic                 MDRout,
   output logic                 IRin,
   output logic                 Gra,
   output logic                 Grb,
   output logic                 Rout,
   output logic                 RYin,
   output logic                 Cout,
   output logic                 Rin,
   output logic                 ADD,
   output logic                 AND,
   output logic                 OR,
   output logic                 halted,
   output logic                 illegal,
   output logic [CNT_WIDTH-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
      S_EXEC3, S_EXEC4, S_EXEC5, S_HALT, S_TRAP
   } state_t;

   typedef struct packed {
      logic pc_out, mar_in, inc_pc, rz_in, read, mdr_in, rz_out, pc_in, mdr_out, ir_in;
      logic gra, grb, r_out, ry_in, c_out, r_in, op_add, op_and, op_or, halted, illegal;
   } strb_t;

   state_t               state_q, state_d;
   logic [4:0]           opc_q, opc_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   strb_t                strb_q, strb_d;
   logic [4:0]           ir_opc;
   logic                 unused_ir;

   assign ir_opc    = ir[OPC_MSB -: 5];
   assign unused_ir = ^ir;

   // Next state, opcode latch, retire counter and strobe decode for the current state
   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      cnt_d   = cnt_q;
      strb_d  = '0;
      case (state_q)
         S_IDLE: if (run) state_d = S_FETCH0;
         S_FETCH0: begin
            strb_d.pc_out = 1'b1;
            strb_d.mar_in = 1'b1;
            strb_d.inc_pc = 1'b1;
            strb_d.rz_in  = 1'b1;
            state_d       = S_FETCH1;
         end
         S_FETCH1: begin
            strb_d.read   = 1'b1;
            strb_d.mdr_in = 1'b1;
            strb_d.rz_out = 1'b1;
            // PC loads only on the cycle the read completes, so it loads once per fetch
            strb_d.pc_in  = mem_ready;
            if (mem_ready) state_d = S_FETCH2;
         end
         S_FETCH2: begin
            strb_d.mdr_out = 1'b1;
            strb_d.ir_in   = 1'b1;
            state_d        = S_DECODE;
         end
         S_DECODE: begin
            opc_d = ir_opc;
            if (ir_opc == OP_ADDI || ir_opc == OP_ANDI || ir_opc == OP_ORI) begin
               state_d = S_EXEC3;
            end else if (ir_opc == OP_HALT) begin
               state_d = S_HALT;
               cnt_d   = cnt_q + CNT_WIDTH'(1);
            end else begin
               state_d = S_TRAP;
            end
         end
         S_EXEC3: begin
            strb_d.grb   = 1'b1;
            strb_d.r_out = 1'b1;
            strb_d.ry_in = 1'b1;
            state_d      = S_EXEC4;
         end
         S_EXEC4: begin
            strb_d.c_out  = 1'b1;
            strb_d.rz_in  = 1'b1;
            strb_d.op_add = (opc_q == OP_ADDI);
            strb_d.op_and = (opc_q == OP_ANDI);
            strb_d.op_or  = (opc_q == OP_ORI);
            state_d       = S_EXEC5;
         end
         S_EXEC5: begin
            strb_d.rz_out = 1'b1;
            strb_d.gra    = 1'b1;
            strb_d.r_in   = 1'b1;
            cnt_d         = cnt_q + CNT_WIDTH'(1);
            state_d       = run ? S_FETCH0 : S_IDLE;
         end
         S_HALT:  strb_d.halted  = 1'b1;
         S_TRAP:  strb_d.illegal = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         opc_q   <= '0;
         cnt_q   <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         cnt_q   <= cnt_d;
         strb_q  <= strb_d;
      end
   end

   assign PCout       = strb_q.pc_out;
   assign MARin       = strb_q.mar_in;
   assign IncPC       = strb_q.inc_pc;
   assign RZin        = strb_q.rz_in;
   assign Read        = strb_q.read;
   assign MDRin       = strb_q.mdr_in;
   assign RZout       = strb_q.rz_out;
   assign PCin        = strb_q.pc_in;
   assign MDRout      = strb_q.mdr_out;
   assign IRin        = strb_q.ir_in;
   assign Gra         = strb_q.gra;
   assign Grb         = strb_q.grb;
   assign Rout        = strb_q.r_out;
   assign RYin        = strb_q.ry_in;
   assign Cout        = strb_q.c_out;
   assign Rin         = strb_q.r_in;
   assign ADD         = strb_q.op_add;
   assign AND         = strb_q.op_and;
   assign OR          = strb_q.op_or;
   assign halted      = strb_q.halted;
   assign illegal     = strb_q.illegal;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_imm_alu_sequencer.sv
// Directed bench for imm_alu_sequencer: vector table for fetch/execute sequences,
// hand-written sequences for trap, halt, mid-instruction reset and counter wrap.
module tb_imm_alu_sequencer;

   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // Strobe vector order: PCout MARin IncPC RZin Read MDRin RZout PCin MDRout IRin
   //                      Gra Grb Rout RYin Cout Rin ADD AND OR halted illegal
   localparam logic [20:0] Z    = 21'h000000;
   localparam logic [20:0] F0   = 21'h1E0000;
   localparam logic [20:0] F1   = 21'h01C000;
   localparam logic [20:0] F1P  = 21'h01E000;
   localparam logic [20:0] F2   = 21'h001800;
   localparam logic [20:0] E3   = 21'h000380;
   localparam logic [20:0] E4   = 21'h020040;
   localparam logic [20:0] XADD = 21'h000010;
   localparam logic [20:0] XAND = 21'h000008;
   localparam logic [20:0] XOR  = 21'h000004;
   localparam logic [20:0] E5   = 21'h004420;
   localparam logic [20:0] HLT  = 21'h000002;
   localparam logic [20:0] ILL  = 21'h000001;

   logic        clk = 1'b0;
   logic        reset, run, mem_ready;
   logic [31:0] ir;
   logic PCout, MARin, IncPC, RZin, Read, MDRin, RZout, PCin, MDRout, IRin;
   logic Gra, Grb, Rout, RYin, Cout, Rin, ADD, AND, OR, halted, illegal;
   logic [1:0]  instr_count;
   logic [20:0] obs;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   imm_alu_sequencer #(.CNT_WIDTH(2)) dut (
      .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .ir(ir),
      .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .RZin(RZin), .Read(Read),
      .MDRin(MDRin), .RZout(RZout), .PCin(PCin), .MDRout(MDRout), .IRin(IRin),
      .Gra(Gra), .Grb(Grb), .Rout(Rout), .RYin(RYin), .Cout(Cout), .Rin(Rin),
      .ADD(ADD), .AND(AND), .OR(OR), .halted(halted), .illegal(illegal),
      .instr_count(instr_count)
   );

   assign obs = {PCout, MARin, IncPC, RZin, Read, MDRin, RZout, PCin, MDRout, IRin,
                 Gra, Grb, Rout, RYin, Cout, Rin, ADD, AND, OR, halted, illegal};

   typedef struct {
      logic        rst_n;
      logic        run;
      logic        mr;
      logic [4:0]  opc;
      logic [20:0] exp;
      logic [1:0]  cnt;
   } vec_t;

   vec_t tbl[21];

   function automatic logic [31:0] mk_ir(input logic [4:0] opc);
      return {opc, 27'h2A5A5A5};
   endfunction

   // One clock: inputs already driven, sample on the following falling edge
   task automatic tick(input logic [20:0] exp, input logic [1:0] ecnt, input string tag);
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s strobes got %h want %h", tag, obs, exp);
      end
      n_cmp++;
      if (instr_count !== ecnt) begin
         n_bad++;
         $display("FAIL %s instr_count got %0d want %0d", tag, instr_count, ecnt);
      end
   endtask

   initial begin
      logic [20:0] seq [7];

      tbl[0]  = '{1'b0, 1'b1, 1'b1, OP_ANDI, Z,         2'd0};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, OP_ANDI, Z,         2'd0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, OP_ANDI, Z,         2'd0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, OP_ANDI, F0,        2'd0};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, OP_ANDI, F1P,       2'd0};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, OP_ANDI, F2,        2'd0};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, OP_ANDI, Z,         2'd0};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, OP_ORI,  E3,        2'd0};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, OP_ORI,  E4 | XAND, 2'd0};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, OP_ADDI, E5,        2'd1};
      tbl[10] = '{1'b1, 1'b1, 1'b1, OP_ADDI, F0,        2'd1};
      tbl[11] = '{1'b1, 1'b1, 1'b0, OP_ADDI, F1,        2'd1};
      tbl[12] = '{1'b1, 1'b1, 1'b0, OP_ADDI, F1,        2'd1};
      tbl[13] = '{1'b1, 1'b1, 1'b1, OP_ADDI, F1P,       2'd1};
      tbl[14] = '{1'b1, 1'b1, 1'b1, OP_ADDI, F2,        2'd1};
      tbl[15] = '{1'b1, 1'b1, 1'b1, OP_ADDI, Z,         2'd1};
      tbl[16] = '{1'b1, 1'b1, 1'b1, OP_ADDI, E3,        2'd1};
      tbl[17] = '{1'b1, 1'b1, 1'b1, OP_ADDI, E4 | XADD, 2'd1};
      tbl[18] = '{1'b1, 1'b0, 1'b1, OP_ADDI, E5,        2'd2};
      tbl[19] = '{1'b1, 1'b0, 1'b1, OP_ADDI, Z,         2'd2};
      tbl[20] = '{1'b1, 1'b0, 1'b1, OP_ADDI, Z,         2'd2};

      reset = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = mk_ir(OP_ANDI);

      // Reset, andi (ir changed to ori mid-execute), addi with two wait cycles, run dropped
      for (int i = 0; i < 21; i++) begin
         reset     = tbl[i].rst_n;
         run       = tbl[i].run;
         mem_ready = tbl[i].mr;
         ir        = mk_ir(tbl[i].opc);
         tick(tbl[i].exp, tbl[i].cnt, $sformatf("vec%0d", i));
      end

      // Illegal opcode traps and holds, counter untouched
      run = 1'b1; ir = mk_ir(5'b00000);
      tick(Z, 2'd2, "trap_idle");
      tick(F0, 2'd2, "trap_f0");
      tick(F1P, 2'd2, "trap_f1");
      tick(F2, 2'd2, "trap_f2");
      tick(Z, 2'd2, "trap_dec");
      tick(ILL, 2'd2, "trap_enter");
      run = 1'b0;
      tick(ILL, 2'd2, "trap_hold");

      // Halt retires one instruction and holds
      reset = 1'b0;
      tick(Z, 2'd0, "halt_rst0");
      tick(Z, 2'd0, "halt_rst1");
      reset = 1'b1; run = 1'b1; ir = mk_ir(OP_HALT);
      tick(Z, 2'd0, "halt_idle");
      tick(F0, 2'd0, "halt_f0");
      tick(F1P, 2'd0, "halt_f1");
      tick(F2, 2'd0, "halt_f2");
      tick(Z, 2'd1, "halt_dec");
      tick(HLT, 2'd1, "halt_enter");
      run = 1'b0;
      tick(HLT, 2'd1, "halt_hold");

      // Reset asserted while in EXEC4 of ori wins over the execute step
      reset = 1'b0;
      tick(Z, 2'd0, "mid_rst0");
      reset = 1'b1; run = 1'b1; ir = mk_ir(OP_ORI);
      tick(Z, 2'd0, "mid_idle");
      tick(F0, 2'd0, "mid_f0");
      tick(F1P, 2'd0, "mid_f1");
      tick(F2, 2'd0, "mid_f2");
      tick(Z, 2'd0, "mid_dec");
      tick(E3, 2'd0, "mid_e3");
      reset = 1'b0;
      tick(Z, 2'd0, "mid_reset");
      reset = 1'b1; run = 1'b0;
      tick(Z, 2'd0, "mid_idle_after");

      // Five back-to-back ori with a 2-bit counter: 1,2,3,0,1; run dropped in the fifth
      seq[0] = F0; seq[1] = F1P; seq[2] = F2; seq[3] = Z;
      seq[4] = E3; seq[5] = E4 | XOR; seq[6] = E5;
      run = 1'b1;
      tick(Z, 2'd0, "wrap_idle");
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 7; j++) begin
            if (i == 4 && j == 4) run = 1'b0;
            tick(seq[j], (j == 6) ? 2'((i + 1) % 4) : 2'(i % 4),
                 $sformatf("wrap_i%0d_s%0d", i, j));
         end
      end
      tick(Z, 2'd1, "wrap_idle_after0");
      tick(Z, 2'd1, "wrap_idle_after1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
